// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional build macro: LSU_ALIGN_CHECK_EN (alignment faults, see top header).
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Width of the bus timeout counter; covers TIMEOUT_CYCLES up to 1023.
    localparam int TO_W = 10;

    // Natural-alignment test: words on 4-byte, halfwords on 2-byte boundaries.
    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        return ((sz == SZ_WORD) && (lo != 2'b00)) || ((sz == SZ_HALF) && lo[0]);
    endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// Combinational byte-lane steering for stores and extraction/extension/rotation
// for loads. Purely a function of the access attributes and the two data words.
module lsu_lane_format
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        mem_write,
    input  logic        sign_ext,
    input  logic [31:0] write_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic        [7:0]  byte_lane;
    logic        [15:0] half_lane;
    logic        [31:0] word_rot;

    // Extension helpers: the signed view makes the size cast replicate the MSB.
    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sx);
        logic signed [7:0] v_s;
        v_s = v;
        return sx ? 32'(v_s) : {24'd0, v};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic sx);
        logic signed [15:0] v_s;
        v_s = v;
        return sx ? 32'(v_s) : {16'd0, v};
    endfunction

    // Store side: replicate the datum onto every lane, enable only the addressed ones.
    always_comb begin
        be    = 4'b1111;
        wdata = write_data;
        if (mem_write) begin
            unique case (size)
                SZ_BYTE: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{write_data[7:0]}};
                end
                SZ_HALF: begin
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{write_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = write_data;
                end
            endcase
        end
    end

    // Load side: pick the addressed lane(s); word loads rotate so the addressed byte lands in [7:0].
    always_comb begin
        unique case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        unique case (addr_lo)
            2'd0:    word_rot = rdata;
            2'd1:    word_rot = {rdata[7:0],  rdata[31:8]};
            2'd2:    word_rot = {rdata[15:0], rdata[31:16]};
            default: word_rot = {rdata[23:0], rdata[31:24]};
        endcase
        unique case (size)
            SZ_BYTE: load_data = ext8(byte_lane, sign_ext);
            SZ_HALF: load_data = ext16(half_lane, sign_ext);
            default: load_data = word_rot;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: IDLE -> REQ -> RESP handshake with a req/ack
// memory bus, timeout abort, and formatted load data return.
// Build macro LSU_ALIGN_CHECK_EN: when defined, misaligned word/halfword
// accesses fault without issuing a bus cycle; when undefined they proceed.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       read_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            hold_q;

    size_e           size_q;
    logic [1:0]      addr_lo_q;
    logic            we_q;
    logic            sx_q;

    size_e           fmt_size;
    logic [1:0]      fmt_lo;
    logic            fmt_we;
    logic            fmt_sx;
    logic [3:0]      fmt_be;
    logic [31:0]     fmt_wdata;
    logic [31:0]     fmt_load;
    logic            bad_access;

    // Formatter sees the live request in IDLE and the latched request afterwards.
    always_comb begin
        if (state_q == ST_IDLE) begin
            fmt_size = size_e'(size);
            fmt_lo   = addr[1:0];
            fmt_we   = mem_write;
            fmt_sx   = sign_ext;
        end else begin
            fmt_size = size_q;
            fmt_lo   = addr_lo_q;
            fmt_we   = we_q;
            fmt_sx   = sx_q;
        end
    end

    // Accesses that must fault before any bus cycle is issued.
    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        bad_access = (size_e'(size) == SZ_RSVD) || misaligned(size_e'(size), addr[1:0]);
`else
        bad_access = (size_e'(size) == SZ_RSVD);
`endif
    end

    lsu_lane_format u_fmt (
        .size       (fmt_size),
        .addr_lo    (fmt_lo),
        .mem_write  (fmt_we),
        .sign_ext   (fmt_sx),
        .write_data (write_data),
        .rdata      (bus_rdata),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .load_data  (fmt_load)
    );

    // Request attributes captured at acceptance; only meaningful while busy.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) begin
            size_q    <= size_e'(size);
            addr_lo_q <= addr[1:0];
            we_q      <= mem_write;
            sx_q      <= sign_ext;
        end
    end

    // Access sequencer with registered bus and completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            read_data <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        cnt_q <= '0;
                        if (bad_access) begin
                            // Spend one extra cycle in RESP so the fault completes at the
                            // same offset from start as a zero-wait bus access.
                            state_q <= ST_RESP;
                            hold_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= fmt_be;
                            bus_wdata <= fmt_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        // Ack wins even in the final allowed cycle.
                        state_q <= ST_RESP;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b0;
                        if (!we_q) begin
                            read_data <= fmt_load;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= ST_RESP;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (hold_q) begin
                        hold_q <= 1'b0;
                        done   <= 1'b1;
                        fault  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        done    <= 1'b0;
                        fault   <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model
// with a per-cycle compare process, directed cases and randomized accesses.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        busy, done, fault, bus_req, bus_we;
    logic [31:0] read_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
        .size(size), .sign_ext(sign_ext), .addr(addr), .write_data(write_data),
        .busy(busy), .done(done), .fault(fault), .read_data(read_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Current transaction as seen by the reference model.
    bit          active = 0;
    int          t0 = 0, done_c = 0, n_req = 0;
    bit          bad_x = 0, flt_x = 0, we_x = 0;
    logic [31:0] e_addr = 0, e_wd = 0, e_ld = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] model_rd = 0;
    bit          rst_prev = 1;

    // Observations from the most recent do_access call.
    int          req_cnt;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_done, obs_fault;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input bit sx,
                                         input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] m;
        logic [63:0] two;
        two = {rd, rd};
        case (sz)
            2'b00: begin
                m = (rd >> (8 * lo)) & 32'hFF;
                if (sx && m >= 32'h80) m = m - 32'h100;
            end
            2'b01: begin
                m = lo[1] ? (rd >> 16) : (rd & 32'hFFFF);
                if (sx && m >= 32'h8000) m = m - 32'h10000;
            end
            2'b10:   m = 32'(two >> (8 * lo));
            default: m = 32'd0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] m_be(input bit we, input logic [1:0] sz, input logic [1:0] lo);
        if (!we) return 4'hF;
        if (sz == 2'b00) return 4'(1 << lo);
        if (sz == 2'b01) return lo[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return 32'(wd[7:0]) * 32'h01010101;
        if (sz == 2'b01) return 32'(wd[15:0]) * 32'h00010001;
        return wd;
    endfunction

    // Per-cycle comparison of every output against the transaction model.
    bit in_req, e_done, e_busy;
    always @(negedge clk) begin
        if (reset) begin
            rst_prev = 1;
        end else begin
            if (rst_prev) model_rd = 32'd0;
            rst_prev = 0;
            in_req = active && !bad_x && (cyc > t0) && (cyc <= t0 + n_req);
            e_done = active && (cyc == done_c);
            e_busy = active && (cyc > t0) && (cyc <= done_c);
            if (e_done && !we_x && !flt_x) model_rd = e_ld;
            chk("busy",      32'(busy),    32'(e_busy));
            chk("done",      32'(done),    32'(e_done));
            chk("fault",     32'(fault),   32'(e_done && flt_x));
            chk("bus_req",   32'(bus_req), 32'(in_req));
            chk("read_data", read_data,    model_rd);
            if (in_req) begin
                chk("bus_addr", bus_addr,     e_addr);
                chk("bus_we",   32'(bus_we),  32'(we_x));
                chk("bus_be",   32'(bus_be),  32'(e_be));
                if (we_x) chk("bus_wdata", bus_wdata, e_wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: d is the 0-based REQ cycle carrying the ack (d >= TO means never).
    task automatic do_access(input bit we, input logic [1:0] sz, input bit sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int d, input bit hold);
        bit bad;
        bad = (sz == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
        if ((sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0])) bad = 1;
`endif
        t0     = cyc;
        we_x   = we;
        bad_x  = bad;
        e_addr = a & 32'hFFFF_FFFC;
        e_be   = m_be(we, sz, a[1:0]);
        e_wd   = m_wd(sz, wd);
        e_ld   = m_ld(sz, sx, a[1:0], rd);
        if (bad) begin
            n_req = 0; flt_x = 1; done_c = t0 + 2;
        end else if (d < TO) begin
            n_req = d + 1; flt_x = 0; done_c = t0 + n_req + 1;
        end else begin
            n_req = TO; flt_x = 1; done_c = t0 + TO + 1;
        end
        active = 1;
        start = 1; mem_write = we; size = sz; sign_ext = sx; addr = a; write_data = wd;
        req_cnt = 0; obs_done = 0; obs_fault = 0;
        obs_addr = 0; obs_be = 0; obs_wdata = 0;
        step();
        if (!hold) start = 0;
        mem_write = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        addr = $urandom; write_data = $urandom;
        while (cyc <= done_c) begin
            if (cyc == t0 + 1) begin
                obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata;
            end
            req_cnt += int'(bus_req);
            if (cyc == done_c) begin
                obs_done = done; obs_fault = fault;
            end
            bus_ack   = (!bad && d < TO && cyc == t0 + 1 + d);
            bus_rdata = bus_ack ? rd : $urandom;
            step();
        end
        bus_ack = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_rd_lit;
        bit          hold;

        repeat (3) step();
        reset = 0;
        step();
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_rdata",   read_data,    32'd0);

        // Pin the reference model itself with hand-computed values.
        chk("model_byte_sx", m_ld(2'b00, 1, 2'd1, 32'h0000_8000), 32'hFFFF_FF80);
        chk("model_rot16",   m_ld(2'b10, 0, 2'd2, 32'h4433_2211), 32'h2211_4433);
        chk("model_be_half", 32'(m_be(1, 2'b01, 2'd3)),           32'h0000_000C);

        // Byte store, ack on the third REQ cycle.
        do_access(1, 2'b00, 0, 32'h1003, 32'h0000_00A5, 32'h0, 2, 0);
        chk("bst_addr",  obs_addr,        32'h0000_1000);
        chk("bst_be",    32'(obs_be),     32'h8);
        chk("bst_wdata", obs_wdata,       32'hA5A5_A5A5);
        chk("bst_reqs",  req_cnt,         3);
        chk("bst_done",  32'(obs_done),   32'd1);
        chk("bst_fault", 32'(obs_fault),  32'd0);

        // Halfword loads, signed then unsigned.
        do_access(0, 2'b01, 1, 32'h2002, 32'h0, 32'h8001_FFFF, 0, 0);
        chk("lh_signed", read_data, 32'hFFFF_8001);
        do_access(0, 2'b01, 0, 32'h2002, 32'h0, 32'h8001_FFFF, 0, 0);
        chk("lh_zero",   read_data, 32'h0000_8001);

        // Misaligned word load.
        do_access(0, 2'b10, 0, 32'h3001, 32'h0, 32'h4433_2211, 1, 0);
`ifdef LSU_ALIGN_CHECK_EN
        chk("lw_mis_reqs",  req_cnt,        0);
        chk("lw_mis_done",  32'(obs_done),  32'd1);
        chk("lw_mis_fault", 32'(obs_fault), 32'd1);
        exp_rd_lit = 32'h0000_8001;
`else
        chk("lw_mis_reqs",  req_cnt,        2);
        chk("lw_mis_fault", 32'(obs_fault), 32'd0);
        exp_rd_lit = 32'h1144_3322;
`endif
        chk("lw_mis_rdata", read_data, exp_rd_lit);

        // Timeout: no ack at all.
        do_access(0, 2'b10, 0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 100, 0);
        chk("to_reqs",  req_cnt,        TO);
        chk("to_done",  32'(obs_done),  32'd1);
        chk("to_fault", 32'(obs_fault), 32'd1);
        chk("to_rdata", read_data,      exp_rd_lit);

        // Ack in the last allowed cycle beats the timeout.
        do_access(1, 2'b01, 0, 32'h7002, 32'h0000_BEEF, 32'h0, TO - 1, 0);
        chk("lastack_reqs",  req_cnt,        TO);
        chk("lastack_fault", 32'(obs_fault), 32'd0);
        chk("lastack_be",    32'(obs_be),    32'hC);

        // Start held high through an access, then back-to-back accesses.
        do_access(1, 2'b10, 0, 32'h8000, 32'h1234_5678, 32'h0, 1, 1);
        do_access(0, 2'b00, 1, 32'h8001, 32'h0, 32'h0000_F000, 0, 1);
        do_access(0, 2'b10, 0, 32'h8004, 32'h0, 32'hCAFE_F00D, 2, 0);
        chk("b2b_rdata", read_data, 32'hCAFE_F00D);

        // Reset while in REQ: no completion, clean restart.
        t0 = cyc; we_x = 0; bad_x = 0; n_req = TO; flt_x = 1; done_c = t0 + TO + 1;
        e_addr = 32'h5000; e_be = 4'hF; e_wd = 0; e_ld = 0; active = 1;
        start = 1; mem_write = 0; size = 2'b10; sign_ext = 0; addr = 32'h5000;
        step();
        start = 0;
        step();
        reset = 1;
        active = 0;
        step();
        reset = 0;
        chk("rst_req_bus_req", 32'(bus_req), 32'd0);
        chk("rst_req_busy",    32'(busy),    32'd0);
        repeat (3) step();
        do_access(0, 2'b01, 1, 32'h6000, 32'h0, 32'h1234_ABCD, 0, 0);
        chk("post_rst_load", read_data, 32'hFFFF_ABCD);

        // Randomized accesses.
        for (int i = 0; i < 150; i++) begin
            hold = (i < 149) && ($urandom_range(0, 3) == 0);
            do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                      $urandom, $urandom_range(0, 5), hold);
            if (!hold) repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle memory access stage downstream of the datapath. It consumes the datapath's data memory address, store data and access attributes, and drives a req/ack data bus to variable-latency memory. It performs byte-lane steering, load extraction and sign/zero extension, and timeout detection. It returns formatted load data with a one-cycle completion pulse, and its busy output stalls the core.

Parameters:
TIMEOUT_CYCLES, 64, bus cycles in REQ before the access is aborted with fault (range 1..1023)
ADDR_W, 32, address width; bus_addr is word-aligned within this width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  access request; sampled only in IDLE
mem_write  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  ADDR_W  byte address (datapath data_memory_addr)
write_data  in  32  store data (datapath write_data)
busy  out  1  high from the cycle after start is accepted until the cycle done is asserted, inclusive
done  out  1  one-cycle completion pulse
fault  out  1  valid with done; 1 = access aborted
read_data  out  32  formatted load data; holds until the next successful load
bus_req  out  1  bus request
bus_we  out  1  bus write enable
bus_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}
bus_be  out  4  byte enables, little-endian
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  memory completion; valid only while bus_req=1
bus_rdata  in  32  read data, valid with bus_ack on loads

Behaviour:
- Reset: all outputs 0, read_data=0, state IDLE, timeout counter 0. Reset mid-access aborts at that edge: bus_req=0 next cycle, no done.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - start=1 latches addr, size, mem_write, sign_ext and write_data, then moves to REQ.
  - Reserved size, or misalignment under ALIGN_CHECK_EN, moves to RESP with fault=1 instead; no bus cycle is issued.
- REQ:
  - bus_req=1; bus_addr, bus_we, bus_be and bus_wdata are registered and stable until exit.
  - bus_ack=1 moves to RESP. On loads, the formatted bus_rdata is captured into read_data at the same edge.
  - The counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES-1 with no ack, bus_req drops, the FSM moves to RESP with fault=1, and read_data is unchanged.
  - Ack in the final cycle wins over timeout.
- RESP: done=1 for one cycle, fault as determined, then IDLE.
  - Minimum latency with zero-wait ack: start at cycle 0, bus_req at cycle 1, ack at cycle 1, done at cycle 2.
- Start handling: start in REQ or RESP is ignored; it is not queued. Start is accepted again in the cycle after done.
- Store lanes:
  - Byte: bus_be = 1 << addr[1:0]; bus_wdata = {4{write_data[7:0]}}.
  - Halfword: bus_be = addr[1] ? 1100 : 0011; bus_wdata = {2{write_data[15:0]}}.
  - Word: bus_be = 1111; bus_wdata = write_data.
  - Loads drive bus_be = 1111.
- Load format:
  - Byte: lane addr[1:0], extended to 32 bits.
  - Halfword: lane addr[1], extended; addr[0] is ignored.
  - Word: bus_rdata rotated right by 8*addr[1:0].
  - sign_ext is ignored for word loads.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined: a word access with addr[1:0]!=0, or a halfword access with addr[0]=1, faults in IDLE. No bus_req is issued; done and fault are asserted 2 cycles after start.
- Undefined: misaligned accesses proceed as described above (word rotation, halfword addr[0] ignored) and never fault for alignment.

Decomposition:
- Package lsu_pkg:
  - access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - FSM state enum;
  - TIMEOUT counter width constant (10 bits).
- One combinational sub-module, lsu_lane_format: store lane/be generation plus load extraction, extension and rotation; the FSM instantiates it once.

Test Plan:
- Byte store, addr=0x1003, write_data=0x000000A5, ack after 3 cycles -> bus_addr=0x1000, bus_be=1000, bus_wdata=0xA5A5A5A5, done 1 cycle after ack, fault=0.
- Signed halfword load, addr=0x2002, bus_rdata=0x8001FFFF -> read_data=0xFFFF8001; same load with sign_ext=0 -> 0x00008001.
- Word load, addr=0x3001, bus_rdata=0x44332211 -> macro off: read_data=0x11443322; macro on: no bus_req, done+fault at start+2.
- No ack, TIMEOUT_CYCLES=4 -> bus_req high exactly 4 cycles, done+fault next cycle, read_data unchanged; ack on the 4th cycle -> fault=0.
- Start held high during a busy access, followed by back-to-back starts -> second access begins only after done; no duplicate bus_req pulses.
- Reset asserted in REQ -> bus_req=0, busy=0 next cycle, no done; a new start afterwards completes normally.
